// File: rtl/trace_capture_pkg.sv
// Shared constants and types for the trace_capture logic-analyser block.
// Holds the register map, control/status bit positions and the capture FSM states.
package trace_capture_pkg;

    localparam int unsigned LANE_W = 32;

    localparam logic [9:0] REG_CTRL      = 10'h000;
    localparam logic [9:0] REG_POST_CNT  = 10'h004;
    localparam logic [9:0] REG_TRIG_ADDR = 10'h008;
    localparam logic [9:0] REG_WR_PTR    = 10'h00C;
    localparam logic [9:0] REG_RD_ADDR   = 10'h010;

    // Upper offset bits select the trigger-register page and the buffer page
    localparam logic [1:0] PAGE_TRIG = 2'b01;
    localparam logic [1:0] PAGE_BUF  = 2'b10;

    localparam int unsigned CTRL_ARM   = 0;
    localparam int unsigned CTRL_ABORT = 1;
    localparam int unsigned CTRL_FORCE = 2;

    localparam int unsigned STAT_IDLE      = 0;
    localparam int unsigned STAT_ARMED     = 1;
    localparam int unsigned STAT_TRIGGERED = 2;
    localparam int unsigned STAT_DONE      = 3;
    localparam int unsigned STAT_WRAPPED   = 4;

    localparam logic [31:0] ID_VAL_DEFAULT = 32'h4c4f4749;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        DONE      = 2'd3
    } state_e;

endpackage

// File: rtl/trace_capture_ram.sv
// Sample buffer: one write port, one synchronous read port with 1-cycle latency.
// Contents are deliberately not reset.
module trace_capture_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_capture.sv
// Logic-analyser capture block: trigger qualifiers, circular sample buffer with
// pre-trigger history and post-trigger count, Wishbone-style register port.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 11,
    parameter logic [31:0] ID_VAL = ID_VAL_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    input  logic [31:0]       wbs_adr_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    output logic              done_o
);

    localparam int unsigned LANES = DATA_W / LANE_W;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  smp_q, smp_d, prev_q, prev_d;
    logic [DATA_W-1:0]  mask_q, mask_d, value_q, value_d;
    logic [DATA_W-1:0]  rise_q, rise_d, fall_q, fall_d;
    logic [ADDR_W-1:0]  post_cnt_q, post_cnt_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               wrapped_q, wrapped_d;
    logic               ack_q, ack_d, done_q, done_d;
    logic [31:0]        dat_q, dat_d;

    logic [9:0]         off_c;
    logic               req_c, wr_c, rd_c, cfg_ok_c, trig_hit_c, buf_hit_c;
    logic               arm_c, abort_c, force_c, trig_c;
    int unsigned        tl_c, bl_c;
    logic [31:0]        status_c, rdata_c;
    logic               ram_we_c;
    logic [DATA_W-1:0]  ram_rdata;
    logic [21:0]        unused_adr;

    assign unused_adr = wbs_adr_i[31:10];

    trace_capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (smp_q),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata)
    );

    // Bus decode and trigger evaluation
    always_comb begin
        off_c      = wbs_adr_i[9:0];
        req_c      = wbs_stb_i & ~ack_q;
        wr_c       = req_c & wbs_we_i;
        rd_c       = req_c & ~wbs_we_i;
        cfg_ok_c   = (state_q == IDLE) || (state_q == DONE);
        tl_c       = 32'(off_c[7:4]);
        bl_c       = 32'(off_c[7:2]);
        trig_hit_c = (off_c[9:8] == PAGE_TRIG) && (tl_c < LANES);
        buf_hit_c  = (off_c[9:8] == PAGE_BUF) && (bl_c < LANES);
        arm_c      = wr_c && (off_c == REG_CTRL) && wbs_dat_i[CTRL_ARM];
        abort_c    = wr_c && (off_c == REG_CTRL) && wbs_dat_i[CTRL_ABORT];
        force_c    = wr_c && (off_c == REG_CTRL) && wbs_dat_i[CTRL_FORCE];
        trig_c     = (((smp_q ^ value_q) & mask_q) == '0)
                  && ((rise_q & ~(~prev_q & smp_q)) == '0)
                  && ((fall_q & ~(prev_q & ~smp_q)) == '0);

        status_c                 = '0;
        status_c[STAT_IDLE]      = (state_q == IDLE);
        status_c[STAT_ARMED]     = (state_q == ARMED);
        status_c[STAT_TRIGGERED] = (state_q == TRIGGERED);
        status_c[STAT_DONE]      = (state_q == DONE);
        status_c[STAT_WRAPPED]   = wrapped_q;

        rdata_c = ID_VAL;
        case (off_c)
            REG_CTRL:      rdata_c = status_c;
            REG_POST_CNT:  rdata_c = 32'(post_cnt_q);
            REG_TRIG_ADDR: rdata_c = 32'(trig_addr_q);
            REG_WR_PTR:    rdata_c = 32'(wr_ptr_q);
            REG_RD_ADDR:   rdata_c = 32'(rd_addr_q);
            default: begin
                if (trig_hit_c) begin
                    case (off_c[3:2])
                        2'd0:    rdata_c = mask_q[LANE_W*tl_c +: LANE_W];
                        2'd1:    rdata_c = value_q[LANE_W*tl_c +: LANE_W];
                        2'd2:    rdata_c = rise_q[LANE_W*tl_c +: LANE_W];
                        default: rdata_c = fall_q[LANE_W*tl_c +: LANE_W];
                    endcase
                end else if (buf_hit_c) begin
                    rdata_c = ram_rdata[LANE_W*bl_c +: LANE_W];
                end
            end
        endcase
    end

    // Next-state: register writes, read latch and capture FSM
    always_comb begin
        state_d     = state_q;
        smp_d       = data_i;
        prev_d      = smp_q;
        mask_d      = mask_q;
        value_d     = value_q;
        rise_d      = rise_q;
        fall_d      = fall_q;
        post_cnt_d  = post_cnt_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        trig_addr_d = trig_addr_q;
        rd_addr_d   = rd_addr_q;
        wrapped_d   = wrapped_q;
        ack_d       = req_c;
        dat_d       = dat_q;
        ram_we_c    = 1'b0;

        if (rd_c) begin
            dat_d = rdata_c;
            if (buf_hit_c && (bl_c == LANES - 1)) begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
        end

        if (wr_c && (off_c == REG_RD_ADDR)) begin
            rd_addr_d = ADDR_W'(wbs_dat_i);
        end

        if (wr_c && cfg_ok_c) begin
            if (off_c == REG_POST_CNT) begin
                post_cnt_d = ADDR_W'(wbs_dat_i);
            end else if (trig_hit_c) begin
                case (off_c[3:2])
                    2'd0:    mask_d[LANE_W*tl_c +: LANE_W]  = wbs_dat_i;
                    2'd1:    value_d[LANE_W*tl_c +: LANE_W] = wbs_dat_i;
                    2'd2:    rise_d[LANE_W*tl_c +: LANE_W]  = wbs_dat_i;
                    default: fall_d[LANE_W*tl_c +: LANE_W]  = wbs_dat_i;
                endcase
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (arm_c && !abort_c) begin
                    state_d   = ARMED;
                    wr_ptr_d  = '0;
                    wrapped_d = 1'b0;
                end
            end
            ARMED, TRIGGERED: begin
                if (abort_c) begin
                    state_d = IDLE;
                end else begin
                    ram_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (&wr_ptr_q) begin
                        wrapped_d = 1'b1;
                    end
                    if (state_q == ARMED) begin
                        if (trig_c || force_c) begin
                            trig_addr_d = wr_ptr_q;
                            cnt_d       = post_cnt_q;
                            state_d     = (post_cnt_q == '0) ? DONE : TRIGGERED;
                        end
                    end else begin
                        cnt_d = cnt_q - ADDR_W'(1);
                        if (cnt_q == ADDR_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            smp_q       <= '0;
            prev_q      <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            post_cnt_q  <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            rd_addr_q   <= '0;
            wrapped_q   <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_q       <= smp_d;
            prev_q      <= prev_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            post_cnt_q  <= post_cnt_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_addr_q <= trig_addr_d;
            rd_addr_q   <= rd_addr_d;
            wrapped_q   <= wrapped_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            done_q      <= done_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture (DATA_W=64, 16-entry buffer).
module tb_trace_capture;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] data_i;
    logic [31:0] wbs_dat_i, wbs_dat_o, wbs_adr_i;
    logic        wbs_ack_o, wbs_stb_i, wbs_we_i, done_o;

    bit          ctr_en;
    int          checks;
    int          errors;
    logic [63:0] exp_buf [16];

    localparam logic [63:0] BIT40 = 64'h0000_0100_0000_0000;

    trace_capture #(
        .DATA_W (64),
        .ADDR_W (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .data_i    (data_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_adr_i (wbs_adr_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .done_o    (done_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Free-running counter on the probed bus when enabled
    initial forever begin
        @(negedge clk_i);
        if (ctr_en) data_i = data_i + 64'd1;
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr,
                           input logic [31:0] wdat, output logic [31:0] rdat);
        bit got;
        got = 1'b0;
        @(negedge clk_i);
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        wbs_we_i  = we;
        wbs_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            if (wbs_ack_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        rdat      = wbs_dat_o;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL bus_ack adr=%h: ack=%b, required 1 within 8 cycles", adr, wbs_ack_o);
        end
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'h0, rdat);
    endtask

    // Polls done_o after each edge; returns the probe value present on that cycle
    task automatic wait_done(input int budget, output bit found, output logic [63:0] d);
        found = 1'b0;
        d     = '0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o === 1'b1) begin
                found = 1'b1;
                d     = data_i;
                break;
            end
        end
        ctr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_ni = 1'b0;
        #23;
        checks++;
        if (wbs_ack_o !== 1'b0 || done_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b done=%b dat=%h, required 0/0/0", wbs_ack_o, done_o, wbs_dat_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        wb_read(32'h000, r);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL reset_status: got %h, required 00000001", r);
        end
    endtask

    task automatic test_level();
        logic [31:0] r, t;
        logic [63:0] d;
        bit          found;
        wb_write(32'h100, 32'hFF);
        wb_write(32'h104, 32'h5A);
        wb_write(32'h004, 32'd4);
        data_i = 64'd0;
        wb_write(32'h000, 32'h1);
        ctr_en = 1'b1;
        wait_done(400, found, d);
        checks++;
        if (!found || d[7:0] !== 8'h5F) begin
            errors++;
            $display("FAIL level_done_timing: found=%b probe=%h, required 1 with probe 5f", found, d[7:0]);
        end
        wb_read(32'h008, t);
        wb_write(32'h010, t);
        for (int i = 0; i < 5; i++) begin
            wb_read(32'h200, r);
            checks++;
            if (r !== 32'h5A + 32'(i)) begin
                errors++;
                $display("FAIL level_buf[+%0d]: got %h, required %h", i, r, 32'h5A + 32'(i));
            end
            wb_read(32'h204, r);
        end
        wb_read(32'h00C, r);
        checks++;
        if (r !== ((t + 32'd5) & 32'hF)) begin
            errors++;
            $display("FAIL level_wr_ptr: got %h, required %h", r, (t + 32'd5) & 32'hF);
        end
    endtask

    task automatic test_edge();
        logic [31:0] r, t;
        wb_write(32'h100, 32'h0);
        wb_write(32'h118, 32'h100);
        wb_write(32'h004, 32'd0);
        @(negedge clk_i);
        data_i = BIT40;
        wb_write(32'h000, 32'h1);
        repeat (4) @(posedge clk_i);
        wb_read(32'h000, r);
        checks++;
        if ((r & 32'hF) !== 32'h2) begin
            errors++;
            $display("FAIL edge_no_trig_at_arm: status %h, required 2", r & 32'hF);
        end
        @(negedge clk_i);
        data_i = 64'd0;
        repeat (3) @(posedge clk_i);
        wb_read(32'h000, r);
        checks++;
        if ((r & 32'hF) !== 32'h2) begin
            errors++;
            $display("FAIL edge_no_trig_on_fall: status %h, required 2", r & 32'hF);
        end
        @(negedge clk_i);
        data_i = BIT40 | 64'h77;
        repeat (4) @(posedge clk_i);
        wb_read(32'h000, r);
        checks++;
        if ((r & 32'hF) !== 32'h8) begin
            errors++;
            $display("FAIL edge_trig_on_rise: status %h, required 8", r & 32'hF);
        end
        wb_read(32'h008, t);
        wb_write(32'h010, t);
        wb_read(32'h200, r);
        checks++;
        if (r !== 32'h77) begin
            errors++;
            $display("FAIL edge_trig_lane0: got %h, required 00000077", r);
        end
        wb_read(32'h204, r);
        checks++;
        if (r !== 32'h100) begin
            errors++;
            $display("FAIL edge_trig_lane1: got %h, required 00000100", r);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] r, w, t, lo;
        logic [63:0] d;
        bit          found;
        int unsigned idx;
        wb_write(32'h100, 32'hFF);
        wb_write(32'h118, 32'h0);
        wb_write(32'h004, 32'd3);
        @(negedge clk_i);
        data_i = 64'h1000;
        wb_write(32'h000, 32'h1);
        ctr_en = 1'b1;
        repeat (20) @(posedge clk_i);
        wb_write(32'h000, 32'h4);
        wait_done(20, found, d);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wrap_done: done_o=%b, required 1", done_o);
        end
        wb_read(32'h000, r);
        checks++;
        if ((r & 32'h1F) !== 32'h18) begin
            errors++;
            $display("FAIL wrap_status: got %h, required 18", r & 32'h1F);
        end
        wb_read(32'h00C, w);
        wb_read(32'h008, t);
        checks++;
        if (t !== ((w + 32'd12) & 32'hF)) begin
            errors++;
            $display("FAIL wrap_trig_addr: got %h, required %h", t, (w + 32'd12) & 32'hF);
        end
        wb_write(32'h010, w);
        for (int i = 0; i < 16; i++) begin
            idx          = (w + 32'(i)) & 32'hF;
            exp_buf[idx] = d - 64'd16 + 64'(i);
            lo           = exp_buf[idx][31:0];
            wb_read(32'h200, r);
            checks++;
            if (r !== lo) begin
                errors++;
                $display("FAIL wrap_buf[%0d]: got %h, required %h", idx, r, lo);
            end
            wb_read(32'h204, r);
        end
    endtask

    task automatic test_readout();
        logic [31:0] r, lo, hi;
        lo = exp_buf[15][31:0];
        hi = exp_buf[15][63:32];
        wb_write(32'h010, 32'd15);
        wb_read(32'h200, r);
        checks++;
        if (r !== lo) begin
            errors++;
            $display("FAIL readout_lane0: got %h, required %h", r, lo);
        end
        wb_read(32'h204, r);
        checks++;
        if (r !== hi) begin
            errors++;
            $display("FAIL readout_lane1: got %h, required %h", r, hi);
        end
        wb_read(32'h010, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL readout_rd_addr_wrap: got %h, required 0", r);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        @(negedge clk_i);
        data_i = 64'd0;
        wb_write(32'h100, 32'h12);
        wb_read(32'h100, r);
        checks++;
        if (r !== 32'h12) begin
            errors++;
            $display("FAIL abort_mask_in_done: got %h, required 12", r);
        end
        wb_write(32'h000, 32'h1);
        wb_write(32'h100, 32'hABCD);
        wb_write(32'h000, 32'h1);
        wb_write(32'h000, 32'h2);
        wb_read(32'h000, r);
        checks++;
        if ((r & 32'hF) !== 32'h1) begin
            errors++;
            $display("FAIL abort_to_idle: status %h, required 1", r & 32'hF);
        end
        wb_read(32'h100, r);
        checks++;
        if (r !== 32'h12) begin
            errors++;
            $display("FAIL abort_mask_dropped: got %h, required 12", r);
        end
        wb_write(32'h000, 32'h3);
        wb_read(32'h000, r);
        checks++;
        if ((r & 32'hF) !== 32'h1) begin
            errors++;
            $display("FAIL arm_abort_same_write: status %h, required 1", r & 32'hF);
        end
        wb_write(32'h000, 32'h4);
        wb_read(32'h000, r);
        checks++;
        if ((r & 32'hF) !== 32'h1) begin
            errors++;
            $display("FAIL force_in_idle: status %h, required 1", r & 32'hF);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        wb_write(32'h100, 32'h0);
        wb_write(32'h004, 32'd15);
        wb_write(32'h000, 32'h1);
        repeat (2) @(posedge clk_i);
        wb_read(32'h000, r);
        checks++;
        if ((r & 32'hF) !== 32'h4) begin
            errors++;
            $display("FAIL mid_triggered: status %h, required 4", r & 32'hF);
        end
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (wbs_ack_o !== 1'b0 || done_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ack=%b done=%b dat=%h, required 0/0/0", wbs_ack_o, done_o, wbs_dat_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wb_read(32'h000, r);
        checks++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL mid_reset_status: got %h, required 00000001", r);
        end
        wb_read(32'h004, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_post_cnt: got %h, required 0", r);
        end
        wb_read(32'h3FC, r);
        checks++;
        if (r !== 32'h4c4f4749) begin
            errors++;
            $display("FAIL unmapped_id: got %h, required 4c4f4749", r);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ctr_en    = 1'b0;
        data_i    = '0;
        wbs_dat_i = '0;
        wbs_adr_i = '0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        test_reset();
        test_level();
        test_edge();
        test_wrap();
        test_readout();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
